req_encoder32: RTL and testbench

- Sequential 32-to-5 request encoder; the inverse of the register-file write-select decoder.
- Captures a 32-bit multi-hot request vector and emits, one per accepted handshake, the 5-bit index of each set bit, lowest index first.
- Sits between event/hazard sources (pending-write masks, interrupt lines) and any consumer that needs a register address stream, e.g. a register-file scrub or writeback sequencer.

---
 rtl/req_encoder32_pkg.sv | 15 +
 rtl/req_encoder32_if.sv | 36 +++
 rtl/req_encoder32_prienc32.sv | 35 +++
 rtl/req_encoder32.sv | 110 +++++++++++
 tb/tb_req_encoder32.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/req_encoder32_pkg.sv
// Shared definitions for the req_encoder32 slice.
//   REQ_W_DEF / ADR_W_DEF : default request width and index width
//   state_t               : encoder FSM state encoding
package req_encoder32_pkg;

  localparam int REQ_W_DEF = 32;
  localparam int ADR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/req_encoder32_if.sv
// Handshake bundle between a request producer/consumer and req_encoder32.
//   req    : multi-hot request vector (producer -> encoder)
//   load   : capture strobe           (producer -> encoder)
//   ready  : consumer accepts adr     (consumer -> encoder)
//   adr    : lowest pending index     (encoder -> consumer)
//   valid  : adr is meaningful
//   busy   : capture in progress, load ignored
//   done   : one-cycle completion pulse
//   remain : number of pending bits
interface req_encoder32_if
  import req_encoder32_pkg::*;
#(
  parameter int REQ_W = REQ_W_DEF,
  parameter int ADR_W = ADR_W_DEF
) ();

  logic [REQ_W-1:0] req;
  logic             load;
  logic             ready;
  logic [ADR_W-1:0] adr;
  logic             valid;
  logic             busy;
  logic             done;
  logic [ADR_W:0]   remain;

  modport master (
    output req, load, ready,
    input  adr, valid, busy, done, remain
  );

  modport slave (
    input  req, load, ready,
    output adr, valid, busy, done, remain
  );

endinterface

// File: rtl/req_encoder32_prienc32.sv
// Combinational lowest-set-bit priority encoder.
//   req : input vector
//   idx : index of the lowest set bit of req (0 when none set)
//   any : at least one bit of req is set
module prienc32 #(
  parameter int REQ_W = 32,
  parameter int ADR_W = 5
) (
  input  logic [REQ_W-1:0] req,
  output logic [ADR_W-1:0] idx,
  output logic             any
);

  // lower[i] is high when some bit below i is set; first is the one-hot
  // isolation of the lowest set bit, and idx is the OR of the indices of
  // its single active line.
  logic [REQ_W-1:0] lower;
  logic [REQ_W-1:0] first;

  always_comb begin
    lower    = '0;
    first    = '0;
    idx      = '0;
    lower[0] = 1'b0;
    for (int i = 1; i < REQ_W; i++) begin
      lower[i] = lower[i-1] | req[i-1];
    end
    for (int i = 0; i < REQ_W; i++) begin
      first[i] = req[i] & ~lower[i];
      idx      = idx | (first[i] ? ADR_W'(i) : '0);
    end
    any = lower[REQ_W-1] | req[REQ_W-1];
  end

endmodule

// File: rtl/req_encoder32.sv
// Sequential request encoder: captures a multi-hot request vector and emits
// the index of each set bit, lowest first, one per accepted handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : req_encoder32_if.slave (req/load/ready in; adr/valid/busy/done/remain out)
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for load; req sampled here only
// ST_SCAN | presenting lowest pending index, valid=1
// ST_FIN  | one-cycle done pulse, then back to idle
module req_encoder32
  import req_encoder32_pkg::*;
#(
  parameter int REQ_W = REQ_W_DEF,
  parameter int ADR_W = ADR_W_DEF
) (
  input logic            clk,
  input logic            rst_n,
  req_encoder32_if.slave bus
);

  if (ADR_W != $clog2(REQ_W)) begin : g_bad_width
    $error("req_encoder32: ADR_W must equal clog2(REQ_W)");
  end

  state_t           state_q, state_d;
  logic [REQ_W-1:0] pending_q;
  logic [ADR_W:0]   remain_q;
  logic [ADR_W-1:0] enc_idx;
  logic             enc_any;
  logic             capture;
  logic             accept;

  function automatic logic [ADR_W:0] popcount(input logic [REQ_W-1:0] v);
    logic [ADR_W:0] n;
    n = '0;
    for (int i = 0; i < REQ_W; i++) begin
      n = n + {{ADR_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

  prienc32 #(
    .REQ_W(REQ_W),
    .ADR_W(ADR_W)
  ) u_prienc (
    .req(pending_q),
    .idx(enc_idx),
    .any(enc_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Last beat is detected from the registered count, so the FIN transition
  // does not wait on the encoder output of the cleared vector.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          if (|bus.req) begin
            capture = 1'b1;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_SCAN: begin
        if (bus.ready && enc_any) begin
          accept = 1'b1;
          if (remain_q == (ADR_W+1)'(1)) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      remain_q  <= '0;
    end else if (capture) begin
      pending_q <= bus.req;
      remain_q  <= popcount(bus.req);
    end else if (accept) begin
      pending_q[enc_idx] <= 1'b0;
      remain_q           <= remain_q - (ADR_W+1)'(1);
    end
  end

  assign bus.valid  = (state_q == ST_SCAN) && enc_any;
  assign bus.adr    = bus.valid ? enc_idx : '0;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_FIN);
  assign bus.remain = remain_q;

endmodule

// File: tb/tb_req_encoder32.sv
// Self-checking bench for req_encoder32: directed sequences with literal
// expectations plus randomized traffic against a set-of-indices model.
module tb_req_encoder32;

  logic clk;
  logic rst_n;

  req_encoder32_if #(.REQ_W(32), .ADR_W(5)) bus ();

  req_encoder32 #(.REQ_W(32), .ADR_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: phase 0 = idle, 1 = emitting indices, 2 = completion cycle.
  // m_pend is the set of indices still to be emitted.
  int          m_phase = 0;
  logic [31:0] m_pend  = '0;

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_pend  = '0;
    end else begin
      case (m_phase)
        0: if (bus.load) begin
             if (bus.req != 0) begin m_pend = bus.req; m_phase = 1; end
             else m_phase = 2;
           end
        1: if (bus.ready) begin
             m_pend[lowest(m_pend)] = 1'b0;
             if (m_pend == 0) m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("m_valid",  {31'd0, bus.valid}, (m_phase == 1) ? 32'd1 : 32'd0);
      chk("m_adr",    {27'd0, bus.adr},   (m_phase == 1) ? lowest(m_pend) : 0);
      chk("m_busy",   {31'd0, bus.busy},  (m_phase != 0) ? 32'd1 : 32'd0);
      chk("m_done",   {31'd0, bus.done},  (m_phase == 2) ? 32'd1 : 32'd0);
      chk("m_remain", {26'd0, bus.remain}, $countones(m_pend));
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_load(input logic [31:0] v);
    bus.req  = v;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.req = '0; bus.load = 1'b0; bus.ready = 1'b0;
    step(); step();
    chk("rst_valid",  {31'd0, bus.valid}, 0);
    chk("rst_adr",    {27'd0, bus.adr}, 0);
    chk("rst_busy",   {31'd0, bus.busy}, 0);
    chk("rst_done",   {31'd0, bus.done}, 0);
    chk("rst_remain", {26'd0, bus.remain}, 0);
    rst_n = 1'b1;
    step();
    chk_en = 1'b1;

    // single bit 0
    bus.ready = 1'b1;
    do_load(32'h0000_0001);
    chk("t1_valid", {31'd0, bus.valid}, 1);
    chk("t1_adr", {27'd0, bus.adr}, 0);
    chk("t1_remain", {26'd0, bus.remain}, 1);
    step();
    chk("t1_done", {31'd0, bus.done}, 1);
    chk("t1_valid_fin", {31'd0, bus.valid}, 0);
    step();
    chk("t1_busy", {31'd0, bus.busy}, 0);

    // 0, 2, 31 back to back
    do_load(32'h8000_0005);
    chk("t2_adr0", {27'd0, bus.adr}, 0);  chk("t2_rem0", {26'd0, bus.remain}, 3);
    step();
    chk("t2_adr1", {27'd0, bus.adr}, 2);  chk("t2_rem1", {26'd0, bus.remain}, 2);
    step();
    chk("t2_adr2", {27'd0, bus.adr}, 31); chk("t2_rem2", {26'd0, bus.remain}, 1);
    step();
    chk("t2_done", {31'd0, bus.done}, 1);
    wait_idle();

    // stalls: ready 0,0,1,0,1 on adr 4,4,4,5,5
    bus.ready = 1'b0;
    do_load(32'h0000_0030);
    begin
      int exp_adr [5] = '{4, 4, 4, 5, 5};
      bit rdy     [5] = '{0, 0, 1, 0, 1};
      for (int i = 0; i < 5; i++) begin
        chk("t3_adr", {27'd0, bus.adr}, exp_adr[i]);
        chk("t3_valid", {31'd0, bus.valid}, 1);
        bus.ready = rdy[i];
        step();
      end
    end
    chk("t3_done", {31'd0, bus.done}, 1);
    wait_idle();

    // zero load, second load during FIN ignored
    bus.ready = 1'b1;
    do_load(32'h0);
    chk("t4_done", {31'd0, bus.done}, 1);
    chk("t4_busy", {31'd0, bus.busy}, 1);
    chk("t4_valid", {31'd0, bus.valid}, 0);
    bus.req = 32'h1; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("t4_ign_busy", {31'd0, bus.busy}, 0);
    chk("t4_ign_valid", {31'd0, bus.valid}, 0);
    step();
    chk("t4_ign_valid2", {31'd0, bus.valid}, 0);

    // reset mid-scan after 10 accepts, then single beat adr=1
    do_load(32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) begin
      chk("t5_adr", {27'd0, bus.adr}, i);
      step();
    end
    chk("t5_adr10", {27'd0, bus.adr}, 10);
    chk("t5_rem10", {26'd0, bus.remain}, 22);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, bus.valid}, 0);
    chk("t5_rst_busy", {31'd0, bus.busy}, 0);
    chk("t5_rst_done", {31'd0, bus.done}, 0);
    chk("t5_rst_remain", {26'd0, bus.remain}, 0);
    chk("t5_rst_adr", {27'd0, bus.adr}, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t5_nodone", {31'd0, bus.done}, 0);
    do_load(32'h0000_0002);
    chk("t5_re_adr", {27'd0, bus.adr}, 1);
    chk("t5_re_rem", {26'd0, bus.remain}, 1);
    step();
    chk("t5_re_done", {31'd0, bus.done}, 1);
    wait_idle();

    // full vector, 32 beats
    do_load(32'hFFFF_FFFF);
    for (int i = 0; i < 32; i++) begin
      chk("t6_adr", {27'd0, bus.adr}, i);
      chk("t6_rem", {26'd0, bus.remain}, 32 - i);
      step();
    end
    chk("t6_done", {31'd0, bus.done}, 1);
    wait_idle();

    // randomized traffic, model checks every cycle
    for (int c = 0; c < 4000; c++) begin
      rst_n     = ($urandom_range(0, 799) != 0);
      bus.load  = ($urandom_range(0, 5) == 0);
      bus.ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0: bus.req = '0;
        1: bus.req = 32'h1 << $urandom_range(0, 31);
        2: bus.req = $urandom;
        3: bus.req = $urandom & $urandom & $urandom;
        default: bus.req = 32'hFFFF_FFFF;
      endcase
      step();
    end
    rst_n = 1'b1;
    bus.load = 1'b0;
    bus.ready = 1'b1;
    step();
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
